// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped UART responder on the j1 I/O port (DATA/STATUS, registered reads).
// Optional define J1_UART_LOOPBACK_EN adds a STATUS-writable loop bit routing TX back into RX.
module j1_uart_io #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] DATA_ADDR    = 16'h1000,
    parameter logic [15:0] STAT_ADDR    = 16'h2000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    txState_t    r_txState, w_txNext;
    rxState_t    r_rxState, w_rxNext;
    logic [15:0] r_txCnt, r_rxCnt;
    logic [2:0]  r_txBit, r_rxBit;
    logic [7:0]  r_txShift, r_rxShift, r_rxData;
    logic        r_rxSync1, r_rxSync2, r_rxPrev;
    logic        r_rxValid, r_rxOverrun, r_rxFerr;
    logic [15:0] r_ioDin;
    logic        w_txLine, w_txReady, w_rxIn, w_loop, w_rxDone;
    logic        w_dataWr, w_dataRd, w_statRd;
    logic        w_unused;

    assign w_dataWr  = io_wr && (io_addr == DATA_ADDR);
    assign w_dataRd  = io_rd && (io_addr == DATA_ADDR);
    assign w_statRd  = io_rd && (io_addr == STAT_ADDR);
    assign w_txReady = (r_txState == TX_IDLE);
    assign w_rxDone  = (r_rxState == RX_STOP) && (r_rxCnt == 16'd0);
    assign w_unused  = ^io_dout[15:8];
    assign io_din    = r_ioDin;

`ifdef J1_UART_LOOPBACK_EN
    logic r_loop;

    always_ff @(posedge clk) begin
        if (!resetq)
            r_loop <= 1'b0;
        else if (io_wr && (io_addr == STAT_ADDR))
            r_loop <= io_dout[0];
    end

    assign w_loop  = r_loop;
    assign w_rxIn  = r_loop ? w_txLine : uart_rx;
    assign uart_tx = r_loop ? 1'b1 : w_txLine;
`else
    assign w_loop  = 1'b0;
    assign w_rxIn  = uart_rx;
    assign uart_tx = w_txLine;
`endif

    always_ff @(posedge clk) begin
        if (!resetq)
            r_txState <= TX_IDLE;
        else
            r_txState <= w_txNext;
    end

    always_comb begin
        w_txNext = r_txState;
        w_txLine = 1'b1;
        case (r_txState)
            TX_IDLE:  if (w_dataWr) w_txNext = TX_START;
            TX_START: begin
                w_txLine = 1'b0;
                if (r_txCnt == 16'd0) w_txNext = TX_DATA;
            end
            TX_DATA: begin
                w_txLine = r_txShift[0];
                if ((r_txCnt == 16'd0) && (r_txBit == 3'd7)) w_txNext = TX_STOP;
            end
            TX_STOP:  if (r_txCnt == 16'd0) w_txNext = TX_IDLE;
            default:  w_txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_txCnt   <= 16'd0;
            r_txBit   <= 3'd0;
            r_txShift <= 8'd0;
        end else if (r_txState == TX_IDLE) begin
            if (w_dataWr) begin
                r_txShift <= io_dout[7:0];
                r_txCnt   <= BIT_LAST;
                r_txBit   <= 3'd0;
            end
        end else if (r_txCnt == 16'd0) begin
            r_txCnt <= BIT_LAST;
            if (r_txState == TX_DATA) begin
                r_txShift <= {1'b0, r_txShift[7:1]};
                r_txBit   <= r_txBit + 3'd1;
            end
        end else begin
            r_txCnt <= r_txCnt - 16'd1;
        end
    end

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= w_rxIn;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq)
            r_rxState <= RX_IDLE;
        else
            r_rxState <= w_rxNext;
    end

    always_comb begin
        w_rxNext = r_rxState;
        case (r_rxState)
            RX_IDLE:  if (r_rxPrev && !r_rxSync2) w_rxNext = RX_START;
            RX_START: if (r_rxCnt == 16'd0) w_rxNext = r_rxSync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if ((r_rxCnt == 16'd0) && (r_rxBit == 3'd7)) w_rxNext = RX_STOP;
            RX_STOP:  if (r_rxCnt == 16'd0) w_rxNext = RX_IDLE;
            default:  w_rxNext = RX_IDLE;
        endcase
    end

    // Idle keeps the half-bit count loaded so the start bit is checked at its midpoint.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_rxCnt   <= 16'd0;
            r_rxBit   <= 3'd0;
            r_rxShift <= 8'd0;
        end else if (r_rxState == RX_IDLE) begin
            r_rxCnt <= HALF_LAST;
            r_rxBit <= 3'd0;
        end else if (r_rxCnt == 16'd0) begin
            r_rxCnt <= BIT_LAST;
            if (r_rxState == RX_DATA) begin
                r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                r_rxBit   <= r_rxBit + 3'd1;
            end
        end else begin
            r_rxCnt <= r_rxCnt - 16'd1;
        end
    end

    // Frame completion is applied after the read-side clears so a new event always wins.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_rxData    <= 8'd0;
            r_rxValid   <= 1'b0;
            r_rxOverrun <= 1'b0;
            r_rxFerr    <= 1'b0;
        end else begin
            if (w_statRd) begin
                r_rxOverrun <= 1'b0;
                r_rxFerr    <= 1'b0;
            end
            if (w_dataRd)
                r_rxValid <= 1'b0;
            if (w_rxDone) begin
                if (r_rxSync2) begin
                    r_rxData  <= r_rxShift;
                    r_rxValid <= 1'b1;
                    if (r_rxValid && !w_dataRd)
                        r_rxOverrun <= 1'b1;
                end else begin
                    r_rxFerr <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq)
            r_ioDin <= 16'd0;
        else if (io_rd) begin
            if (io_addr == DATA_ADDR)
                r_ioDin <= {8'd0, r_rxData};
            else if (io_addr == STAT_ADDR)
                r_ioDin <= {11'd0, w_loop, r_rxFerr, r_rxOverrun, r_rxValid, w_txReady};
            else
                r_ioDin <= 16'd0;
        end
    end

endmodule

// File: doc/j1_uart_io.md
Name: j1_uart_io

Overview:
- Memory-mapped UART responder on the j1 I/O data port, the target end of the CPU's io_rd/io_wr bus.
- CPU writes a byte to DATA to transmit it. CPU reads DATA to fetch the last received byte, and reads STATUS to poll flags.
- Read data is registered (1-cycle latency), matching the synchronous-RAM timing the j1 already expects on its data port.
- Sits beside the program/data RAM in the top-level; drives the board's uart_tx pin and samples uart_rx.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range 4..65535.
- DATA_ADDR, 16'h1000: io_addr of the DATA register.
- STAT_ADDR, 16'h2000: io_addr of the STATUS register.

Ports:
- clk  in  1  system clock
- resetq  in  1  synchronous active-low reset
- io_wr  in  1  CPU I/O write strobe, one cycle per access
- io_rd  in  1  CPU I/O read strobe, one cycle per access
- io_addr  in  16  CPU I/O address
- io_dout  in  16  CPU write data; bits [7:0] used for DATA
- io_din  out  16  read data, valid the cycle after io_rd
- uart_tx  out  1  serial output, idle high
- uart_rx  in  1  serial input, asynchronous

Behaviour:
- Reset (resetq=0 at posedge clk): uart_tx=1, io_din=0, TX idle, RX idle, rx_valid=0, rx_overrun=0, rx_ferr=0, rx_data=0.
- Reset asserted mid-frame aborts the frame immediately. uart_tx returns high on the next edge.
- Address decode:
  - Exact 16-bit compare.
  - Accesses to any other address are ignored.
  - A read of any other address returns io_din=0.
  - io_rd and io_wr asserted together: the write takes effect and the read returns the pre-write value.
- Read timing:
  - io_din is updated only in the cycle after io_rd=1.
  - io_din holds its value otherwise.
- STATUS read value: {12'b0, rx_ferr, rx_overrun, rx_valid, tx_ready}.
  - Reading STATUS clears rx_overrun and rx_ferr; io_din still shows their pre-clear values.
- DATA read value: {8'b0, rx_data}. Reading DATA clears rx_valid.
- TX path:
  - tx_ready=1 when the TX state is IDLE.
  - A DATA write while tx_ready=1 latches io_dout[7:0] and enters START in the next cycle.
  - A DATA write while tx_ready=0 is discarded silently.
- TX FSM: IDLE -> START (uart_tx=0) -> DATA x8, LSB first -> STOP (uart_tx=1) -> IDLE.
  - Each state/bit lasts exactly CLKS_PER_BIT cycles.
  - Total frame length is 10*CLKS_PER_BIT cycles.
  - tx_ready rises in the first cycle after STOP completes.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: waits for a 1->0 transition of the synchronised input.
  - START: samples at CLKS_PER_BIT/2. If the sample is 1, it is a glitch: return to IDLE with no flags changed.
  - DATA: samples 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
  - STOP: samples the stop bit.
- Frame completion:
  - Stop bit = 1: rx_data <= shifted byte, rx_valid <= 1. If rx_valid was already 1 (not cleared this cycle), rx_overrun <= 1.
  - Stop bit = 0: byte discarded, rx_ferr <= 1, rx_valid unchanged.
- Frame completion in the same cycle as a DATA read:
  - The new byte is loaded and rx_valid stays 1.
  - No overrun is flagged.
  - io_din shows the old byte.
- Counters: the bit counter is 16 bits wide and reloads to CLKS_PER_BIT-1 at each bit boundary. No free-running wrap.

Optional Feature:
- Macro: J1_UART_LOOPBACK_EN.
- Defined:
  - Adds a 1-bit loop register, written via io_dout[0] on a STATUS write (reset value 0).
  - When loop=1, the RX synchroniser input is the internal TX serial line instead of uart_rx, and the uart_tx pin is held at 1.
  - STATUS read returns loop in bit 4.
- Undefined:
  - STATUS writes are ignored.
  - Bit 4 reads 0.
  - No loop register exists.

Test Plan:
- Reset, then read STATUS -> io_din=16'h0001 one cycle later; uart_tx=1.
- CLKS_PER_BIT=4, write DATA 16'h00A5 -> uart_tx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_ready=0 for 40 cycles, then 1.
- Second DATA write of 16'h005A issued 3 cycles into the A5 frame -> ignored; only the A5 frame appears, and no second frame follows.
- Drive uart_rx with byte 8'h3C (valid stop) -> STATUS=16'h0003. DATA read returns 16'h003C. The following STATUS read returns 16'h0001.
- Receive 8'h11 then 8'h22 with no DATA read in between -> STATUS=16'h0007. DATA read returns 16'h0022. A second STATUS read returns 16'h0001.
- Frame with stop bit 0 -> STATUS bit3=1 and rx_valid=0. A 1-cycle low glitch on uart_rx -> no flag change. With J1_UART_LOOPBACK_EN, write STATUS 16'h0001, then DATA 16'h0077 -> DATA read returns 16'h0077 and the uart_tx pin stays 1.
